uart_core: RTL and testbench

8N1 UART with independent transmitter and receiver sharing one system clock (nominally 50 MHz). The transmitter serialises a byte written on a single-cycle strobe; the receiver oversamples the serial input at 16x, recovers bytes and presents them behind a sticky ready flag. It sits between a host-side register interface and the board's serial pins, and supports tx-to-rx loopback.

---
 rtl/uart_core.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: 8N1 UART, transmitter and 16x-oversampling receiver on one clock.
// Optional feature macro: UART_RX_SYNC_EN. When it is defined, rx passes
// through a two-flop synchroniser (reset high) ahead of the receiver. When it
// is undefined, rx must already be synchronous to clk_50m.
module uart_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);

    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
    localparam int TX_CW  = $clog2(TX_DIV + 1);
    localparam int RX_CW  = $clog2(RX_DIV + 1);
    localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(TX_DIV - 1);
    localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_bit_end_s;

    assign tx_bit_end_s = (tx_cnt_q == TX_LAST);

    // Transmitter state register and datapath registers
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= {TX_CW{1'b0}};
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Transmitter next-state: each frame element lasts exactly TX_DIV cycles
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_en) begin
                    tx_state_d = TX_START;
                    tx_shift_d = din;
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = {TX_CW{1'b0}};
                end else begin
                    tx_cnt_d   = {TX_CW{1'b0}};
                end
            end
            TX_START: begin
                if (tx_bit_end_s) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = {TX_CW{1'b0}};
                end else begin
                    tx_cnt_d   = tx_cnt_q + TX_CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s) begin
                    tx_cnt_d = {TX_CW{1'b0}};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + TX_CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = {TX_CW{1'b0}};
                end else begin
                    tx_cnt_d   = tx_cnt_q + TX_CW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = {TX_CW{1'b0}};
            end
        endcase
    end

    // Transmitter outputs decoded from the next state so they register in step with it
    always_comb begin
        case (tx_state_d)
            TX_IDLE:  begin tx_d = 1'b1;          tx_busy_d = 1'b0; end
            TX_START: begin tx_d = 1'b0;          tx_busy_d = 1'b1; end
            TX_DATA:  begin tx_d = tx_shift_d[0]; tx_busy_d = 1'b1; end
            TX_STOP:  begin tx_d = 1'b1;          tx_busy_d = 1'b1; end
            default:  begin tx_d = 1'b1;          tx_busy_d = 1'b0; end
        endcase
    end

    // Registered transmitter outputs; reset forces the line idle high at once
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    assign rx_s = rx_sync_q[1];
`else
    assign rx_s = rx;
`endif

    logic [RX_CW-1:0] rx_div_q;
    logic             rx_tick_s;

    assign rx_tick_s = (rx_div_q == RX_LAST);

    // Free-running 16x oversampling tick generator
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_div_q <= {RX_CW{1'b0}};
        end else if (rx_tick_s) begin
            rx_div_q <= {RX_CW{1'b0}};
        end else begin
            rx_div_q <= rx_div_q + RX_CW'(1);
        end
    end

    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_smp_q, rx_smp_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_load_s;
    logic       rdy_q, rdy_d;
    logic [7:0] dout_q, dout_d;

    // Receiver state register and sample/shift registers
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_smp_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_smp_q   <= rx_smp_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver next-state: verify start at mid-bit, then sample every 16 ticks
    always_comb begin
        rx_state_d = rx_state_q;
        rx_smp_d   = rx_smp_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_tick_s && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_smp_d   = 4'd1;
                end else begin
                    rx_smp_d   = 4'd0;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    if (rx_smp_q == 4'd8) begin
                        rx_smp_d = 4'd0;
                        rx_bit_d = 3'd0;
                        if (!rx_s) begin
                            rx_state_d = RX_DATA;
                        end else begin
                            rx_state_d = RX_IDLE;
                        end
                    end else begin
                        rx_smp_d = rx_smp_q + 4'd1;
                    end
                end else begin
                    rx_smp_d = rx_smp_q;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    if (rx_smp_q == 4'd15) begin
                        rx_smp_d             = 4'd0;
                        rx_shift_d[rx_bit_q] = rx_s;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d   = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_smp_d = rx_smp_q + 4'd1;
                    end
                end else begin
                    rx_smp_d = rx_smp_q;
                end
            end
            RX_STOP: begin
                if (rx_tick_s) begin
                    if (rx_smp_q == 4'd15) begin
                        rx_smp_d = 4'd0;
                        if (rx_s) begin
                            rx_load_s  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            // Framing error: drop the byte, wait for the line to recover
                            rx_state_d = RX_WAIT;
                        end
                    end else begin
                        rx_smp_d = rx_smp_q + 4'd1;
                    end
                end else begin
                    rx_smp_d = rx_smp_q;
                end
            end
            RX_WAIT: begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_smp_d   = 4'd0;
            end
        endcase
    end

    // Ready flag and data holding: a new byte has priority over a clear
    always_comb begin
        if (rx_load_s) begin
            rdy_d  = 1'b1;
            dout_d = rx_shift_q;
        end else if (rdy_clr) begin
            rdy_d  = 1'b0;
            dout_d = dout_q;
        end else begin
            rdy_d  = rdy_q;
            dout_d = dout_q;
        end
    end

    // Registered receiver outputs
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            dout_q <= 8'h00;
        end else begin
            rdy_q  <= rdy_d;
            dout_q <= dout_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core. Runs at a reduced line rate (16 clocks
// per bit, one oversampling tick per clock) so the full loopback sweep stays short.
module tb_uart_core;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int TXD      = CLK_FREQ / BAUD;
    localparam int RXD      = CLK_FREQ / (16 * BAUD);

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rdy;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;

    logic       rx_drv   = 1'b1;
    logic       loop_en  = 1'b0;
    logic       mon_en   = 1'b0;
    logic       seen_rdy = 1'b0;
    logic [7:0] last_rx  = 8'h00;
    logic [7:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    assign rx = loop_en ? tx : rx_drv;

    uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_50m (clk),
        .rst_n   (rst_n),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 12 * TXD && tx_busy; i++) step();
        check_eq("tx_idle_wait", tx_busy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 * TXD && exp_q.size() != 0; i++) step();
        check_eq("rx_drain", exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic tx_send(input logic [7:0] b);
        wait_tx_idle();
        din   = b;
        wr_en = 1'b1;
        if (loop_en) exp_q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    // Transmit one byte and compare the line against the ideal 8N1 waveform.
    task automatic frame_chk(input logic [7:0] b, input logic inject);
        int   k;
        logic eb;
        wait_tx_idle();
        din   = b;
        wr_en = 1'b1;
        if (loop_en) exp_q.push_back(b);
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 10 * TXD; i++) begin
            k  = i / TXD;
            eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check_eq("tx_bit", tx, eb);
            check_eq("tx_busy_frame", tx_busy, 1);
            if (inject && i == 5 * TXD) begin
                din   = 8'h3C;
                wr_en = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        check_eq("tx_busy_end", tx_busy, 0);
        check_eq("tx_idle_end", tx, 1);
    endtask

    // Drive one frame on rx directly; stop_ok=0 produces a framing error.
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        if (stop_ok && mon_en) exp_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            rx_drv = bits[k];
            for (int c = 0; c < TXD; c++) begin
                step();
                if (rdy) seen_rdy = 1'b1;
            end
        end
        rx_drv = 1'b1;
    endtask

    // Receive monitor: every rdy must match the next expected byte, then clear it.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (rdy_clr) begin
                    rdy_clr = 1'b0;
                    check_eq("rdy_after_clr", rdy, 0);
                end else if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rdy_spurious", rdy, 0);
                    end else begin
                        check_eq("rx_byte", dout, exp_q[0]);
                        last_rx = exp_q.pop_front();
                    end
                    rdy_clr = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, r2, b3;
        int         cnt, gap;
        logic       ok;

        repeat (3) step();
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_rdy", rdy, 0);
        check_eq("rst_dout", dout, 0);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // 0xA5 waveform in loopback, with a 0x3C request mid-frame that must be ignored
        loop_en = 1'b1;
        frame_chk(8'hA5, 1'b1);
        drain();
        check_eq("a5_only", last_rx, 8'hA5);

        // Full byte sweep in loopback
        for (int v = 0; v < 256; v++) begin
            tx_send(v[7:0]);
            drain();
        end
        check_eq("sweep_last", last_rx, 8'hFF);

        // Back-to-back with wr_en held high
        wait_tx_idle();
        r1    = 8'($urandom);
        r2    = 8'($urandom);
        din   = r1;
        wr_en = 1'b1;
        exp_q.push_back(r1);
        step();
        din = r2;
        cnt = 0;
        for (int i = 0; i < 12 * TXD && tx_busy; i++) begin
            cnt++;
            step();
        end
        check_eq("b2b_frame_len", cnt, 10 * TXD);
        exp_q.push_back(r2);
        step();
        wr_en = 1'b0;
        check_eq("b2b_restart_busy", tx_busy, 1);
        check_eq("b2b_restart_tx", tx, 0);
        drain();

        // Random loopback bytes with stray requests during the frame
        for (int n = 0; n < 8; n++) begin
            tx_send(8'($urandom));
            repeat ($urandom_range(1, 8 * TXD)) step();
            din   = 8'($urandom);
            wr_en = 1'b1;
            step();
            wr_en = 1'b0;
            drain();
        end

        // Short low glitch on rx must be rejected
        loop_en = 1'b0;
        rx_drv  = 1'b0;
        repeat (4 * RXD) step();
        rx_drv = 1'b1;
        repeat (2 * TXD) step();
        check_eq("glitch_rdy", rdy, 0);

        // Framing error then a valid frame
        rx_frame(8'h55, 1'b0);
        repeat (2 * TXD) step();
        check_eq("ferr_rdy", rdy, 0);
        check_eq("ferr_dout", dout, last_rx);
        rx_frame(8'h12, 1'b1);
        drain();
        check_eq("after_ferr_dout", dout, 8'h12);

        // Random direct frames, some with framing errors
        for (int n = 0; n < 24; n++) begin
            ok = ($urandom_range(0, 3) != 0);
            rx_frame(8'($urandom), ok);
            gap = $urandom_range(1, 2 * TXD) + (ok ? 0 : TXD);
            repeat (gap) step();
        end
        drain();

        // Overwrite while rdy is still high
        mon_en = 1'b0;
        repeat (3) step();
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        rx_frame(r1, 1'b1);
        rx_frame(r2, 1'b1);
        step();
        check_eq("ovw_rdy", rdy, 1);
        check_eq("ovw_dout", dout, r2);

        // Set and clear in the same cycle: set wins
        rdy_clr  = 1'b1;
        step();
        seen_rdy = 1'b0;
        b3       = 8'($urandom_range(1, 255));
        rx_frame(b3, 1'b1);
        check_eq("set_wins", seen_rdy, 1);
        check_eq("set_wins_dout", dout, b3);
        check_eq("set_wins_cleared", rdy, 0);
        rdy_clr = 1'b0;
        exp_q.delete();
        last_rx = b3;
        step();

        // Reset during a transmit data phase
        mon_en  = 1'b1;
        loop_en = 1'b1;
        tx_send(8'h5A);
        repeat (3 * TXD) step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tx", tx, 1);
        check_eq("midrst_busy", tx_busy, 0);
        check_eq("midrst_rdy", rdy, 0);
        check_eq("midrst_dout", dout, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        frame_chk(8'hC3, 1'b0);
        drain();
        check_eq("post_rst_rx", last_rx, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
